// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract unit: DATA_WIDTH bits split into SEG_WIDTH-bit
// full_adder chains with one register stage per segment and a global-stall handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module pipelined_rca #(
  parameter int DATA_WIDTH = 16,
  parameter int SEG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);
  localparam int NUM_SEG = DATA_WIDTH / SEG_WIDTH;

  // Handshake: a beat moves when valid && ready are both high at a rising edge.
  // The whole pipe advances unless the final stage holds a result nobody takes,
  // so in_ready depends only on out_valid/out_ready, never on in_valid.
  logic                  advance;
  logic [DATA_WIDTH-1:0] eb;
  logic                  c0;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign eb       = in_sub ? ~in_b : in_b;
  assign c0       = in_sub | in_cin;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    localparam int LO  = k * SEG_WIDTH;
    localparam int REM = DATA_WIDTH - LO;

    // a_in/b_in hold the operand bits not yet consumed; the low SEG_WIDTH are this segment's.
    logic [REM-1:0]          a_in;
    logic [REM-1:0]          b_in;
    logic                    c_in;
    logic                    v_in;
    logic [SEG_WIDTH-1:0]    s_seg;
    logic [LO+SEG_WIDTH-1:0] sum_nxt;
    logic [LO+SEG_WIDTH-1:0] sum_q;
    logic                    v_q;
    logic                    c_q;

    if (k == 0) begin : g_src
      assign a_in    = in_a;
      assign b_in    = eb;
      assign c_in    = c0;
      assign v_in    = in_valid;
      assign sum_nxt = s_seg;
    end else begin : g_src
      assign a_in    = g_seg[k-1].g_skew.a_q;
      assign b_in    = g_seg[k-1].g_skew.b_q;
      assign c_in    = g_seg[k-1].c_q;
      assign v_in    = g_seg[k-1].v_q;
      assign sum_nxt = {s_seg, g_seg[k-1].sum_q};
    end

    for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
      logic ci;
      logic co;
      if (i == 0) begin : g_first
        assign ci = c_in;
      end else begin : g_chain
        assign ci = g_bit[i-1].co;
      end
      full_adder u_fa (
        .a    (a_in[i]),
        .b    (b_in[i]),
        .cin  (ci),
        .sum  (s_seg[i]),
        .cout (co)
      );
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= g_bit[SEG_WIDTH-1].co;
        sum_q <= sum_nxt;
      end
    end

    if (k < NUM_SEG - 1) begin : g_skew
      logic [REM-SEG_WIDTH-1:0] a_q;
      logic [REM-SEG_WIDTH-1:0] b_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[REM-1:SEG_WIDTH];
          b_q <= b_in[REM-1:SEG_WIDTH];
        end
      end
    end else begin : g_last
      // Signed overflow: carry into the MSB differs from carry out of it.
      logic ovf_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= g_bit[SEG_WIDTH-1].ci ^ g_bit[SEG_WIDTH-1].co;
        end
      end
    end
  end

  assign out_valid = g_seg[NUM_SEG-1].v_q;
  assign out_sum   = g_seg[NUM_SEG-1].sum_q;
  assign out_cout  = g_seg[NUM_SEG-1].c_q;
  assign out_ovf   = g_seg[NUM_SEG-1].g_last.ovf_q;

endmodule
